// File: rtl/alu_datapath_if.sv
// Bus between control_unit and alu_datapath: operation select, operand bus,
// control strobes c0..c7 and the registered status/result returned to the sequencer.
interface alu_datapath_if #(
  parameter int WIDTH = 8
);
  logic [1:0]         op;
  logic [WIDTH-1:0]   in_data;
  logic               c0, c1, c2, c3, c4, c5, c6, c7;
  logic               q0;
  logic               qm1;
  logic               a7;
  logic               cnt_done;
  logic [2*WIDTH-1:0] result;
  // result_valid is a one-cycle valid with no ready: the consumer must take
  // result in the cycle result_valid is high; result holds until the next c7.
  logic               result_valid;
  logic               protocol_err;
  logic               ovf;

  modport master (
    output op, in_data, c0, c1, c2, c3, c4, c5, c6, c7,
    input  q0, qm1, a7, cnt_done, result, result_valid, protocol_err, ovf
  );

  modport slave (
    input  op, in_data, c0, c1, c2, c3, c4, c5, c6, c7,
    output q0, qm1, a7, cnt_done, result, result_valid, protocol_err, ovf
  );
endinterface

// File: rtl/alu_datapath.sv
// Booth-multiply / restoring-divide datapath: M, A, Q, Q[-1] and iteration counter,
// driven by control strobes. Optional sticky overflow flag under `ALU_OVF_FLAG_EN.
module alu_datapath #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  alu_datapath_if.slave bus
);
  localparam int                CNT_W   = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               rv_q, rv_d;
  logic               perr_q, perr_d;

  logic [WIDTH-1:0]   alu_res;
  logic               unused_op1;

  // op[1] only matters to control_unit; the datapath obeys strobes in every mode.
  assign unused_op1 = bus.op[1];
  assign alu_res    = bus.c3 ? (a_q - m_q) : (a_q + m_q);

`ifdef ALU_OVF_FLAG_EN
  logic ovf_q, ovf_d;
  logic ovf_hit;

  // Add overflows when like-signed operands give an opposite-signed result;
  // subtract overflows when unlike-signed operands flip the sign of A.
  always_comb begin
    if (bus.c3) begin
      ovf_hit = (a_q[WIDTH-1] != m_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
    end else begin
      ovf_hit = (a_q[WIDTH-1] == m_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (bus.c0) begin
      ovf_d = 1'b0;
    end else if (bus.c2 && ovf_hit) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  always_comb begin
    m_d      = m_q;
    a_d      = a_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    cnt_d    = cnt_q;
    perr_d   = perr_q;
    result_d = bus.c7 ? {a_q, q_q} : result_q;
    rv_d     = bus.c7;

    if (bus.c0) begin
      // A c0 cycle clears everything; an accompanying c4 is still flagged.
      m_d    = bus.in_data;
      a_d    = '0;
      q_d    = bus.c1 ? bus.in_data : '0;
      qm1_d  = 1'b0;
      cnt_d  = '0;
      perr_d = bus.c4;
    end else begin
      if (bus.c2) begin
        a_d = alu_res;
      end
      if (bus.c2 && bus.c4) begin
        perr_d = 1'b1;
      end else if (bus.c4) begin
        if (bus.op[0]) begin
          a_d = {a_q[WIDTH-2:0], q_q[WIDTH-1]};
          q_d = {q_q[WIDTH-2:0], bus.c6};
        end else begin
          a_d   = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
          q_d   = {a_q[0], q_q[WIDTH-1:1]};
          qm1_d = q_q[0];
        end
      end
      // A Q load in the same cycle takes precedence over the shifted Q.
      if (bus.c1) begin
        q_d = bus.in_data;
      end
      if (bus.c5 && (cnt_q < CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q      <= '0;
      a_q      <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      m_q      <= m_d;
      a_q      <= a_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      perr_q   <= perr_d;
    end
  end

  assign bus.q0           = q_q[0];
  assign bus.qm1          = qm1_q;
  assign bus.a7           = a_q[WIDTH-1];
  assign bus.cnt_done     = (cnt_q == CNT_MAX);
  assign bus.result       = result_q;
  assign bus.result_valid = rv_q;
  assign bus.protocol_err = perr_q;
endmodule

// File: tb/tb_alu_datapath.sv
// Directed self-checking bench for alu_datapath (WIDTH=8); expected values are
// hand-computed constants, with ovf expectations following `ALU_OVF_FLAG_EN.
module tb_alu_datapath;
  localparam int WIDTH = 8;
  localparam logic [7:0] C0 = 8'h01, C1 = 8'h02, C2 = 8'h04, C3 = 8'h08;
  localparam logic [7:0] C4 = 8'h10, C5 = 8'h20, C6 = 8'h40, C7 = 8'h80;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [2*WIDTH-1:0] exp_q[$];
  logic ovf_exp;

  alu_datapath_if #(.WIDTH(WIDTH)) bus ();

  alu_datapath #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_strb(input logic [7:0] s);
    bus.c0 = s[0]; bus.c1 = s[1]; bus.c2 = s[2]; bus.c3 = s[3];
    bus.c4 = s[4]; bus.c5 = s[5]; bus.c6 = s[6]; bus.c7 = s[7];
  endtask

  task automatic cyc(input logic [7:0] s, input logic [7:0] d);
    @(negedge clk);
    bus.in_data = d;
    drive_strb(s);
    @(posedge clk);
    #1;
    drive_strb(8'h00);
  endtask

  function automatic logic [6:0] status();
    return {bus.q0, bus.qm1, bus.a7, bus.cnt_done, bus.result_valid, bus.protocol_err, bus.ovf};
  endfunction

  // scoreboard: push expected {A,Q}, pulse c7, compare the pulse and payload
  task automatic snap(input string tag, input logic [2*WIDTH-1:0] exp);
    exp_q.push_back(exp);
    cyc(C7, 8'h00);
    check({tag, "_valid"}, 32'(bus.result_valid), 32'd1);
    if (exp_q.size() != 0) begin
      check(tag, 32'(bus.result), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
`ifdef ALU_OVF_FLAG_EN
    ovf_exp = 1'b1;
`else
    ovf_exp = 1'b0;
`endif
    bus.op      = 2'b11;
    bus.in_data = 8'hFF;
    drive_strb(8'hFF);
    rst = 1'b1;

    // 1. reset with every strobe asserted
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_status", 32'(status()), 32'd0);
      check("rst_result", 32'(bus.result), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_strb(8'h00);
    bus.op = 2'b10;
    @(posedge clk);
    #1;
    check("post_rst_status", 32'(status()), 32'd0);

    // 2. load and add/sub
    cyc(C0, 8'h05);
    cyc(C1, 8'h03);
    check("load_q0", 32'(bus.q0), 32'd1);
    check("load_a7", 32'(bus.a7), 32'd0);
    snap("load_aq", 16'h0003);
    cyc(C2, 8'h00);
    snap("add_aq", 16'h0503);
    cyc(C2 | C3, 8'h00);
    snap("sub_aq", 16'h0003);
    check("no_ovf", 32'(bus.ovf), 32'd0);
    cyc(C0 | C1, 8'h07);
    snap("c0c1_aq", 16'h0007);

    // 3. Booth arithmetic right shift
    cyc(C0, 8'h85);
    cyc(C1, 8'h01);
    cyc(C2, 8'h00);
    bus.op = 2'b10;
    cyc(C4, 8'h00);
    check("mul_a7", 32'(bus.a7), 32'd1);
    check("mul_qm1", 32'(bus.qm1), 32'd1);
    check("mul_q0", 32'(bus.q0), 32'd0);
    snap("mul_aq", 16'hC280);

    // 4. divide left shift, qm1 set beforehand to show it holds
    cyc(C0, 8'h01);
    cyc(C1, 8'h01);
    cyc(C4, 8'h00);
    check("pre_div_qm1", 32'(bus.qm1), 32'd1);
    cyc(C1, 8'h80);
    cyc(C2, 8'h00);
    bus.op = 2'b11;
    cyc(C4 | C6, 8'h00);
    check("div_qm1", 32'(bus.qm1), 32'd1);
    snap("div_aq", 16'h0301);

    // 5. iteration counter and saturation
    cyc(C0, 8'h00);
    repeat (7) cyc(C5, 8'h00);
    check("cnt7_done", 32'(bus.cnt_done), 32'd0);
    cyc(C5, 8'h00);
    check("cnt8_done", 32'(bus.cnt_done), 32'd1);
    cyc(C5, 8'h00);
    check("cnt9_done", 32'(bus.cnt_done), 32'd1);
    check("sat_no_err", 32'(bus.protocol_err), 32'd0);
    cyc(C0, 8'h00);
    check("cnt_clr", 32'(bus.cnt_done), 32'd0);

    // 6. collisions and result pulse
    cyc(C0, 8'h09);
    cyc(C1, 8'h34);
    cyc(C2, 8'h00);
    bus.op = 2'b10;
    cyc(C2 | C4, 8'h00);
    check("coll_perr", 32'(bus.protocol_err), 32'd1);
    check("coll_qm1", 32'(bus.qm1), 32'd0);
    snap("coll_aq", 16'h1234);
    cyc(8'h00, 8'h00);
    check("rv_one_cycle", 32'(bus.result_valid), 32'd0);
    check("perr_sticky", 32'(bus.protocol_err), 32'd1);
    check("result_hold", 32'(bus.result), 32'h1234);
    cyc(C0 | C4, 8'h55);
    check("c0c4_perr", 32'(bus.protocol_err), 32'd1);
    snap("c0c4_aq", 16'h0000);
    cyc(C0, 8'h00);
    check("perr_clr", 32'(bus.protocol_err), 32'd0);

    // overflow: shift 0x7F from Q into A, then 0x7F + 0x01
    cyc(C0, 8'h01);
    cyc(C1, 8'h7F);
    bus.op = 2'b11;
    repeat (8) cyc(C4, 8'h00);
    snap("ovf_pre_aq", 16'h7F00);
    check("ovf_pre", 32'(bus.ovf), 32'd0);
    cyc(C2, 8'h00);
    check("ovf_set", 32'(bus.ovf), 32'(ovf_exp));
    check("ovf_a7", 32'(bus.a7), 32'd1);
    cyc(8'h00, 8'h00);
    check("ovf_sticky", 32'(bus.ovf), 32'(ovf_exp));
    cyc(C0, 8'h00);
    check("ovf_clr", 32'(bus.ovf), 32'd0);

    // reset mid-operation overrides strobes
    cyc(C1, 8'hAB);
    @(negedge clk);
    rst = 1'b1;
    drive_strb(C2 | C4 | C5 | C7);
    @(posedge clk);
    #1;
    check("midop_rst_status", 32'(status()), 32'd0);
    check("midop_rst_result", 32'(bus.result), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive_strb(8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
